// File: rtl/router_vc_param.sv
`default_nettype none
// ============================================================================
// Module   : router_vc_param
// Purpose  : Bidirectional-ring router node with clockwise (cw),
//            counter-clockwise (ccw) and processing-element (pe) ports.
//            Each port has two virtual channels (VC0/VC1), one input and
//            one output FIFO per VC, each DEPTH entries deep. A global
//            polarity bit alternates every cycle: external links move the
//            VC equal to polarity, while internal routing moves the other VC.
//            Ring packets are routed by hop count and PE packets by their
//            direction bit. Each contended output has a round-robin arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW     packet width (>= 16)
//   HOP_W  hop-count field width; field occupies pkt[DW-9 -: HOP_W]
//   DEPTH  entries per VC FIFO (1..8)
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   polarity            global VC phase, toggles every cycle
//   cwsi/ccwsi/pesi     send-in strobes from cw/ccw neighbour and PE
//   cwri/ccwri/peri     ready-in: input FIFO of VC==polarity not full
//   cwdi/ccwdi/pedi     input packets
//   cwso/ccwso/peso     send-out: output FIFO of VC==polarity not empty
//   cwro/ccwro/pero     ready-out from downstream
//   cwdo/ccwdo/pedo     output packets (zero when the matching *so is low)
//   proto_err           sticky: a packet was offered with VC bit != polarity
// ============================================================================
module router_vc_param #(
    parameter int DW    = 64,
    parameter int HOP_W = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          polarity,
    input  logic          cwsi,
    input  logic          ccwsi,
    input  logic          pesi,
    output logic          cwri,
    output logic          ccwri,
    output logic          peri,
    input  logic [DW-1:0] cwdi,
    input  logic [DW-1:0] ccwdi,
    input  logic [DW-1:0] pedi,
    output logic          cwso,
    output logic          ccwso,
    output logic          peso,
    input  logic          cwro,
    input  logic          ccwro,
    input  logic          pero,
    output logic [DW-1:0] cwdo,
    output logic [DW-1:0] ccwdo,
    output logic [DW-1:0] pedo,
    output logic          proto_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int HOP_LSB = DW - 8 - HOP_W;

    // Port indices shared by inputs and outputs.
    localparam logic [1:0] PORT_CW  = 2'd0;
    localparam logic [1:0] PORT_CCW = 2'd1;
    localparam logic [1:0] PORT_PE  = 2'd2;

    // Requester pair per output: A is the ring input the pointer favours
    // after reset, B is the other requester.
    //   cw out  : A = cw in,  B = pe in
    //   ccw out : A = ccw in, B = pe in
    //   pe out  : A = cw in,  B = ccw in
    localparam int SRC_A [3] = '{0, 1, 0};
    localparam int SRC_B [3] = '{2, 2, 1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              pol_q;
    logic              perr_q;

    logic [DW-1:0]     in_mem_q  [3][2][DEPTH];
    logic [PTR_W-1:0]  in_rd_q   [3][2];
    logic [PTR_W-1:0]  in_wr_q   [3][2];
    logic [CNT_W-1:0]  in_cnt_q  [3][2];

    logic [DW-1:0]     out_mem_q [3][2][DEPTH];
    logic [PTR_W-1:0]  out_rd_q  [3][2];
    logic [PTR_W-1:0]  out_wr_q  [3][2];
    logic [CNT_W-1:0]  out_cnt_q [3][2];

    // Round-robin pointer per output per VC: 0 favours SRC_A, 1 favours SRC_B.
    logic              rr_q      [3][2];
    logic              rr_d      [3][2];

    // ------------------------------------------------------------------------
    // Port bundling
    // ------------------------------------------------------------------------
    logic              si_w      [3];
    logic [DW-1:0]     di_w      [3];
    logic              ro_w      [3];
    logic              ri_w      [3];
    logic              so_w      [3];
    logic [DW-1:0]     do_w      [3];

    assign si_w[0] = cwsi;
    assign si_w[1] = ccwsi;
    assign si_w[2] = pesi;
    assign di_w[0] = cwdi;
    assign di_w[1] = ccwdi;
    assign di_w[2] = pedi;
    assign ro_w[0] = cwro;
    assign ro_w[1] = ccwro;
    assign ro_w[2] = pero;

    assign cwri  = ri_w[0];
    assign ccwri = ri_w[1];
    assign peri  = ri_w[2];
    assign cwso  = so_w[0];
    assign ccwso = so_w[1];
    assign peso  = so_w[2];
    assign cwdo  = do_w[0];
    assign ccwdo = do_w[1];
    assign pedo  = do_w[2];

    assign polarity  = pol_q;
    assign proto_err = perr_q;

    // Internal transfers always operate on the VC opposite the link phase.
    logic nq_w;
    assign nq_w = ~pol_q;

    // ------------------------------------------------------------------------
    // External link side (VC == polarity)
    // ------------------------------------------------------------------------
    logic in_push_w  [3];
    logic out_pop_w  [3];
    logic perr_set_w;

    always_comb begin
        perr_set_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ri_w[i]      = (in_cnt_q[i][pol_q] != CNT_W'(DEPTH));
            in_push_w[i] = si_w[i] & ri_w[i] & (di_w[i][DW-1] == pol_q);
            // A wrong VC bit is flagged even when the FIFO happens to be full.
            if (si_w[i] && (di_w[i][DW-1] != pol_q)) begin
                perr_set_w = 1'b1;
            end
        end
        for (int o = 0; o < 3; o++) begin
            so_w[o]      = (out_cnt_q[o][pol_q] != '0);
            do_w[o]      = so_w[o] ? out_mem_q[o][pol_q][out_rd_q[o][pol_q]] : '0;
            out_pop_w[o] = so_w[o] & ro_w[o];
        end
    end

    // ------------------------------------------------------------------------
    // Routing of input FIFO heads (VC == !polarity)
    // ------------------------------------------------------------------------
    logic              head_vld_w [3];
    logic [DW-1:0]     head_w     [3];
    logic [HOP_W-1:0]  hop_w      [3];
    logic [1:0]        dst_w      [3];
    logic [DW-1:0]     fwd_w      [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            head_vld_w[i] = (in_cnt_q[i][nq_w] != '0);
            head_w[i]     = in_mem_q[i][nq_w][in_rd_q[i][nq_w]];
            hop_w[i]      = head_w[i][HOP_LSB +: HOP_W];
            fwd_w[i]      = head_w[i];
            if (i == 2) begin
                // PE injections keep their hop count; only the dir bit matters.
                dst_w[i] = head_w[i][DW-2] ? PORT_CCW : PORT_CW;
            end else if (hop_w[i] <= HOP_W'(1)) begin
                // Arrived: deliver to the local PE with the count cleared.
                dst_w[i] = PORT_PE;
                fwd_w[i][HOP_LSB +: HOP_W] = '0;
            end else begin
                dst_w[i] = 2'(i);
                fwd_w[i][HOP_LSB +: HOP_W] = hop_w[i] - HOP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration per output (VC == !polarity)
    // ------------------------------------------------------------------------
    logic              req_a_w    [3];
    logic              req_b_w    [3];
    logic              win_b_w    [3];
    logic              ofull_w    [3];
    logic              in_pop_w   [3];
    logic              out_push_w [3];
    logic [DW-1:0]     out_data_w [3];

    always_comb begin
        rr_d = rr_q;
        for (int i = 0; i < 3; i++) begin
            in_pop_w[i] = 1'b0;
        end
        for (int o = 0; o < 3; o++) begin
            req_a_w[o]    = head_vld_w[SRC_A[o]] && (dst_w[SRC_A[o]] == 2'(o));
            req_b_w[o]    = head_vld_w[SRC_B[o]] && (dst_w[SRC_B[o]] == 2'(o));
            ofull_w[o]    = (out_cnt_q[o][nq_w] == CNT_W'(DEPTH));
            // B wins when alone, or when both request and the pointer favours B.
            win_b_w[o]    = req_b_w[o] && (!req_a_w[o] || rr_q[o][nq_w]);
            out_push_w[o] = (req_a_w[o] || req_b_w[o]) && !ofull_w[o];
            out_data_w[o] = win_b_w[o] ? fwd_w[SRC_B[o]] : fwd_w[SRC_A[o]];
            if (out_push_w[o]) begin
                if (win_b_w[o]) begin
                    in_pop_w[SRC_B[o]] = 1'b1;
                end else begin
                    in_pop_w[SRC_A[o]] = 1'b1;
                end
                // Priority passes to the requester that was not just served.
                rr_d[o][nq_w] = ~win_b_w[o];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Push (link phase VC) and pop (internal phase VC) of an input FIFO never
    // hit the same VC in one cycle, and likewise for output FIFOs, so each
    // counter sees at most one change per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pol_q  <= 1'b0;
            perr_q <= 1'b0;
            rr_q   <= '{default: 1'b0};
            for (int i = 0; i < 3; i++) begin
                for (int v = 0; v < 2; v++) begin
                    in_rd_q[i][v]   <= '0;
                    in_wr_q[i][v]   <= '0;
                    in_cnt_q[i][v]  <= '0;
                    out_rd_q[i][v]  <= '0;
                    out_wr_q[i][v]  <= '0;
                    out_cnt_q[i][v] <= '0;
                end
            end
        end else begin
            pol_q <= ~pol_q;
            if (perr_set_w) begin
                perr_q <= 1'b1;
            end
            rr_q <= rr_d;
            for (int i = 0; i < 3; i++) begin
                if (in_push_w[i]) begin
                    in_mem_q[i][pol_q][in_wr_q[i][pol_q]] <= di_w[i];
                    in_wr_q[i][pol_q]  <= ptr_inc(in_wr_q[i][pol_q]);
                    in_cnt_q[i][pol_q] <= in_cnt_q[i][pol_q] + 1'b1;
                end
                if (in_pop_w[i]) begin
                    in_rd_q[i][nq_w]  <= ptr_inc(in_rd_q[i][nq_w]);
                    in_cnt_q[i][nq_w] <= in_cnt_q[i][nq_w] - 1'b1;
                end
            end
            for (int o = 0; o < 3; o++) begin
                if (out_push_w[o]) begin
                    out_mem_q[o][nq_w][out_wr_q[o][nq_w]] <= out_data_w[o];
                    out_wr_q[o][nq_w]  <= ptr_inc(out_wr_q[o][nq_w]);
                    out_cnt_q[o][nq_w] <= out_cnt_q[o][nq_w] + 1'b1;
                end
                if (out_pop_w[o]) begin
                    out_rd_q[o][pol_q]  <= ptr_inc(out_rd_q[o][pol_q]);
                    out_cnt_q[o][pol_q] <= out_cnt_q[o][pol_q] - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_vc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_vc_param
// Purpose  : Self-checking bench for router_vc_param. A queue-based model of
//            the router's FIFOs, routing rules and round-robin priority is
//            advanced at every clock edge; every output is compared with it
//            each cycle. Directed scenarios precede a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_vc_param;

    localparam int DW    = 64;
    localparam int HOP_W = 8;
    localparam int DEPTH = 2;

    typedef logic [DW-1:0] pkt_t;

    logic    clk = 1'b0;
    logic    reset;
    logic    polarity;
    logic    si   [3];
    logic    ri   [3];
    pkt_t    di   [3];
    logic    so   [3];
    logic    ro   [3];
    pkt_t    dout [3];
    logic    proto_err;

    always #5 clk = ~clk;

    router_vc_param #(.DW(DW), .HOP_W(HOP_W), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .cwsi      (si[0]),
        .ccwsi     (si[1]),
        .pesi      (si[2]),
        .cwri      (ri[0]),
        .ccwri     (ri[1]),
        .peri      (ri[2]),
        .cwdi      (di[0]),
        .ccwdi     (di[1]),
        .pedi      (di[2]),
        .cwso      (so[0]),
        .ccwso     (so[1]),
        .peso      (so[2]),
        .cwro      (ro[0]),
        .ccwro     (ro[1]),
        .pero      (ro[2]),
        .cwdo      (dout[0]),
        .ccwdo     (dout[1]),
        .pedo      (dout[2]),
        .proto_err (proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one queue per FIFO, priority kept as a source port id.
    // ------------------------------------------------------------------------
    pkt_t m_in  [3][2][$];
    pkt_t m_out [3][2][$];
    int   m_prio[3][2];
    bit   m_pol;
    bit   m_perr;
    pkt_t delivered_cw[$];

    // Requester pairs: cw out <- cw/pe, ccw out <- ccw/pe, pe out <- cw/ccw.
    int pa [3] = '{0, 1, 0};
    int pb [3] = '{2, 2, 1};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 2; v++) begin
                m_in[i][v].delete();
                m_out[i][v].delete();
                m_prio[i][v] = pa[i];
            end
        end
        m_pol  = 1'b0;
        m_perr = 1'b0;
    endtask

    function automatic void route(input int src, input pkt_t h, output int dst, output pkt_t f);
        int hop;
        hop = int'(h[DW-9 -: HOP_W]);
        f   = h;
        if (src == 2) begin
            dst = h[DW-2] ? 1 : 0;
        end else if (hop <= 1) begin
            dst = 2;
            f[DW-9 -: HOP_W] = '0;
        end else begin
            dst = src;
            f[DW-9 -: HOP_W] = HOP_W'(hop - 1);
        end
    endfunction

    task automatic model_step();
        int   p;
        int   q;
        bit   has [3];
        int   dst [3];
        pkt_t fwd [3];
        int   cand[$];
        int   w;
        p = int'(m_pol);
        q = 1 - p;
        // Link phase on VC p.
        for (int i = 0; i < 3; i++) begin
            if (si[i]) begin
                if (di[i][DW-1] != m_pol) m_perr = 1'b1;
                else if (m_in[i][p].size() < DEPTH) m_in[i][p].push_back(di[i]);
            end
            if (ro[i] && m_out[i][p].size() > 0) void'(m_out[i][p].pop_front());
        end
        // Internal phase on VC q.
        for (int i = 0; i < 3; i++) begin
            has[i] = m_in[i][q].size() > 0;
            dst[i] = -1;
            fwd[i] = '0;
            if (has[i]) route(i, m_in[i][q][0], dst[i], fwd[i]);
        end
        for (int o = 0; o < 3; o++) begin
            cand.delete();
            for (int i = 0; i < 3; i++) if (has[i] && dst[i] == o) cand.push_back(i);
            if (cand.size() > 0 && m_out[o][q].size() < DEPTH) begin
                w = (cand.size() == 2) ? m_prio[o][q] : cand[0];
                m_out[o][q].push_back(fwd[w]);
                void'(m_in[w][q].pop_front());
                m_prio[o][q] = (w == pa[o]) ? pb[o] : pa[o];
            end
        end
        m_pol = ~m_pol;
    endtask

    task automatic do_checks();
        int p;
        p = int'(m_pol);
        check("polarity", polarity, m_pol);
        check("proto_err", proto_err, m_perr);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ri%0d", i), ri[i], m_in[i][p].size() < DEPTH);
            check($sformatf("so%0d", i), so[i], m_out[i][p].size() > 0);
            check($sformatf("do%0d", i), dout[i], (m_out[i][p].size() > 0) ? m_out[i][p][0] : '0);
        end
        if (so[0] && ro[0]) delivered_cw.push_back(dout[0]);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then return 1 time unit later so new stimulus can be driven.
    task automatic step();
        @(negedge clk);
        do_checks();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            si[i] = 1'b0;
            di[i] = '0;
            ro[i] = 1'b1;
        end
    endtask

    task automatic wait_pol(input bit v);
        for (int k = 0; k < 4 && m_pol != v; k++) step();
    endtask

    function automatic pkt_t mkpkt(input bit vc, input bit dir, input int hop);
        pkt_t x;
        x = {$urandom, $urandom};
        x[DW-1] = vc;
        x[DW-2] = dir;
        x[DW-9 -: HOP_W] = HOP_W'(hop);
        return x;
    endfunction

    pkt_t pk  [4];
    pkt_t a;
    pkt_t b;
    pkt_t exp;

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        model_reset();
        #1;
        step();
        step();
        reset = 1'b0;
        repeat (4) step();

        // cw in, hop 3 -> cw out with hop 2 two cycles later.
        wait_pol(1'b0);
        a = mkpkt(1'b0, 1'b0, 3);
        si[0] = 1'b1; di[0] = a;
        step();
        idle();
        step();
        #3;
        exp = a; exp[DW-9 -: HOP_W] = 8'd2;
        check("t2_cwso", so[0], 1'b1);
        check("t2_cwdo", dout[0], exp);
        repeat (4) step();

        // ccw in on VC1, hop 1 -> pe out with hop 0.
        wait_pol(1'b1);
        a = mkpkt(1'b1, 1'b1, 1);
        si[1] = 1'b1; di[1] = a;
        step();
        idle();
        step();
        #3;
        exp = a; exp[DW-9 -: HOP_W] = '0;
        check("t3_peso", so[2], 1'b1);
        check("t3_pedo", dout[2], exp);
        repeat (4) step();

        // Tie at pe out: cw input wins, ccw follows two cycles later.
        wait_pol(1'b0);
        a = mkpkt(1'b0, 1'b0, 1);
        b = mkpkt(1'b0, 1'b1, 1);
        si[0] = 1'b1; di[0] = a;
        si[1] = 1'b1; di[1] = b;
        step();
        idle();
        step();
        #3;
        exp = a; exp[DW-9 -: HOP_W] = '0;
        check("t4_first", dout[2], exp);
        step();
        step();
        #3;
        exp = b; exp[DW-9 -: HOP_W] = '0;
        check("t4_second", dout[2], exp);
        repeat (4) step();

        // Back-pressure on cw out: four packets fill 2 + 2 entries.
        ro[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_pol(1'b0);
            pk[k] = mkpkt(1'b0, 1'b0, 5);
            si[0] = 1'b1; di[0] = pk[k];
            step();
            si[0] = 1'b0;
        end
        wait_pol(1'b0);
        step();
        wait_pol(1'b0);
        #3;
        check("t5_cwri_full", ri[0], 1'b0);
        check("t5_cwso_held", so[0], 1'b1);
        delivered_cw.delete();
        ro[0] = 1'b1;
        repeat (14) step();
        check("t5_count", 64'(delivered_cw.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            exp = pk[k]; exp[DW-9 -: HOP_W] = 8'd4;
            check($sformatf("t5_pkt%0d", k), (k < delivered_cw.size()) ? delivered_cw[k] : '0, exp);
        end

        // Wrong VC bit on the PE link: dropped, sticky error.
        wait_pol(1'b0);
        si[2] = 1'b1; di[2] = mkpkt(1'b1, 1'b0, 1);
        step();
        idle();
        step();
        #3;
        check("t6_perr_set", proto_err, 1'b1);
        repeat (6) step();
        #3;
        check("t6_perr_sticky", proto_err, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #3;
        check("t6_perr_clear", proto_err, 1'b0);

        // Randomized traffic with occasional protocol errors and resets.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 3; i++) begin
                si[i] = $urandom_range(0, 1) == 1;
                di[i] = mkpkt(($urandom_range(0, 299) == 0) ? ~m_pol : m_pol,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 4));
                ro[i] = $urandom_range(0, 3) != 0;
            end
            step();
        end
        reset = 1'b0;
        idle();
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
